trivium_stream_core: RTL

//  Parametrised, self-contained Trivium stream-cipher unit processing DAT_W bits per clock.
//  Key/IV arrive over a valid/ready config channel. Data arrives over valid/ready in/out channels.

---
 rtl/trivium_stream_core.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/trivium_stream_core.sv
// Trivium stream cipher with a DAT_W-bit datapath and valid/ready config, input and output channels.
// Key/IV are shifted in serially, followed by a configurable warm-up. Text is then XORed with the keystream.
module trivium_stream_core #(
    parameter int DAT_W         = 1,
    parameter int WARMUP_ROUNDS = 1152
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             init_i,
    input  logic             abort_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [DAT_W-1:0] cfg_dat_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DAT_W-1:0] in_dat_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DAT_W-1:0] out_dat_o,
    output logic             out_last_o,
    output logic             busy_init_o
);

    localparam int CFG_BEATS = 160 / DAT_W;
    localparam int WU_CYC    = WARMUP_ROUNDS / DAT_W;
    localparam int CNT_MAX   = (CFG_BEATS > WU_CYC) ? CFG_BEATS : WU_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    generate
        if (!(DAT_W == 1 || DAT_W == 2 || DAT_W == 4 || DAT_W == 8 || DAT_W == 16 || DAT_W == 32)
            || (WARMUP_ROUNDS % DAT_W) != 0 || WARMUP_ROUNDS < DAT_W) begin : g_param_err
            $error("trivium_stream_core: illegal DAT_W / WARMUP_ROUNDS combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WARMUP = 3'd3,
        ST_PROC   = 3'd4
    } state_t;

    // Vector bit i holds Trivium state bit s(i+1).
    function automatic logic [287:0] trivium_round(input logic [287:0] s);
        logic t1;
        logic t2;
        logic t3;
        t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
        t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
        t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
        return {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    function automatic logic ks_bit(input logic [287:0] s);
        return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [159:0]       r_cfg;
    logic [287:0]       r_s;
    logic [287:0]       w_s_adv;
    logic [DAT_W-1:0]   w_ks;
    logic               r_out_valid;
    logic [DAT_W-1:0]   r_out_dat;
    logic               r_out_last;
    logic               w_cfg_rdy;
    logic               w_in_rdy;
    logic               w_busy;
    logic               w_cfg_acc;
    logic               w_in_acc;

    assign w_cfg_acc   = w_cfg_rdy & cfg_valid_i & ~abort_i;
    assign w_in_acc    = w_in_rdy & in_valid_i & ~abort_i;
    assign cfg_ready_o = w_cfg_rdy;
    assign in_ready_o  = w_in_rdy;
    assign busy_init_o = w_busy;
    assign out_valid_o = r_out_valid;
    assign out_dat_o   = r_out_dat;
    assign out_last_o  = r_out_last;

    // FSM state register
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; abort overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init_i) w_state_nxt = ST_RECV;
                    else        w_state_nxt = ST_IDLE;
                end
                ST_RECV: begin
                    if (w_cfg_acc && r_cnt == CNT_W'(CFG_BEATS - 1)) w_state_nxt = ST_LOAD;
                    else                                             w_state_nxt = ST_RECV;
                end
                ST_LOAD: w_state_nxt = ST_WARMUP;
                ST_WARMUP: begin
                    if (r_cnt == CNT_W'(WU_CYC - 1)) w_state_nxt = ST_PROC;
                    else                              w_state_nxt = ST_WARMUP;
                end
                ST_PROC: begin
                    if (w_in_acc && in_last_i) w_state_nxt = ST_IDLE;
                    else                       w_state_nxt = ST_PROC;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: handshake readies and init-busy flag
    always_comb begin
        w_cfg_rdy = 1'b0;
        w_in_rdy  = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            ST_RECV:   w_cfg_rdy = 1'b1;
            ST_LOAD:   w_busy    = 1'b1;
            ST_WARMUP: w_busy    = 1'b1;
            ST_PROC:   w_in_rdy  = ~r_out_valid | out_ready_i;
            default:   w_cfg_rdy = 1'b0;
        endcase
    end

    // Beat counter in RECV, cycle counter in WARMUP
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_cnt <= '0;
        end else if (abort_i) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_RECV: begin
                    if (w_cfg_acc) begin
                        r_cnt <= (r_cnt == CNT_W'(CFG_BEATS - 1)) ? '0 : r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                ST_WARMUP: r_cnt <= (r_cnt == CNT_W'(WU_CYC - 1)) ? '0 : r_cnt + CNT_W'(1);
                default:   r_cnt <= '0;
            endcase
        end
    end

    // Config shift register: after 160 bits, r_cfg[k] is the k-th bit received
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_cfg <= '0;
        end else if (w_cfg_acc) begin
            r_cfg <= {cfg_dat_i, r_cfg[159:DAT_W]};
        end else begin
            r_cfg <= r_cfg;
        end
    end

    // DAT_W unrolled rounds; keystream bit i comes from round i
    always_comb begin
        w_ks    = '0;
        w_s_adv = r_s;
        for (int i = 0; i < DAT_W; i++) begin
            w_ks[i] = ks_bit(w_s_adv);
            w_s_adv = trivium_round(w_s_adv);
        end
    end

    // Core state: loaded once, free-running in WARMUP, advanced per accepted beat in PROC
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_s <= '0;
        end else begin
            case (r_state)
                ST_LOAD:   r_s <= {3'b111, 108'd0, 4'd0, r_cfg[159:80], 13'd0, r_cfg[79:0]};
                ST_WARMUP: r_s <= w_s_adv;
                ST_PROC:   r_s <= w_in_acc ? w_s_adv : r_s;
                default:   r_s <= r_s;
            endcase
        end
    end

    // Output register with backpressure; drains in any state
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_out_valid <= 1'b0;
            r_out_dat   <= '0;
            r_out_last  <= 1'b0;
        end else if (abort_i) begin
            r_out_valid <= 1'b0;
        end else if (w_in_acc) begin
            r_out_valid <= 1'b1;
            r_out_dat   <= in_dat_i ^ w_ks;
            r_out_last  <= in_last_i;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

endmodule
